// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES decryption controller: state register, round counter, inverse-round datapath.
// Optional key_len_i port (AES-128/192/256 selection) is enabled with `define AES_INV_KEYLEN_EN.

module inv_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] aff, pw, acc;
  // Inverse affine map, then GF(2^8) inverse as x^254 = x^2 * x^4 * ... * x^128
  always_comb begin
    aff = {a_i[6:0], a_i[7]} ^ {a_i[4:0], a_i[7:5]} ^ {a_i[1:0], a_i[7:2]} ^ 8'h05;
    pw  = aff;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      pw  = gmul(pw, pw);
      acc = gmul(acc, pw);
    end
    y_o = acc;
  end
endmodule

module invmixcolumns (
  input  logic [127:0] d_i,
  output logic [127:0] q_o
);
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] m9(input logic [7:0] a);
    return xt(xt(xt(a))) ^ a;
  endfunction
  function automatic logic [7:0] mb(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(a) ^ a;
  endfunction
  function automatic logic [7:0] md(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
  endfunction
  function automatic logic [7:0] me(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = d_i[127-32*c -: 8];
    assign a1 = d_i[119-32*c -: 8];
    assign a2 = d_i[111-32*c -: 8];
    assign a3 = d_i[103-32*c -: 8];
    assign q_o[127-32*c -: 8] = me(a0) ^ mb(a1) ^ md(a2) ^ m9(a3);
    assign q_o[119-32*c -: 8] = m9(a0) ^ me(a1) ^ mb(a2) ^ md(a3);
    assign q_o[111-32*c -: 8] = md(a0) ^ m9(a1) ^ me(a2) ^ mb(a3);
    assign q_o[103-32*c -: 8] = mb(a0) ^ md(a1) ^ m9(a2) ^ me(a3);
  end
endmodule

module aes_inv_round_ctrl #(
  parameter int NR_DEFAULT = 10,
  parameter int KIDX_W     = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [127:0]      in_data_i,
  output logic [KIDX_W-1:0] key_idx_o,
  input  logic [127:0]      round_key_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [127:0]      out_data_o,
  output logic              busy_o
`ifdef AES_INV_KEYLEN_EN
  ,
  input  logic [1:0]        key_len_i
`endif
);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;

  state_e             state_q, state_d;
  logic [127:0]       st_q, st_d;
  logic [KIDX_W-1:0]  rnd_q, rnd_d;
  logic [KIDX_W-1:0]  nr_live;
  logic [127:0]       sb, ark, mix;

  // Nr only matters at accept: it seeds the round counter, which then runs down to 0.
`ifdef AES_INV_KEYLEN_EN
  always_comb begin
    case (key_len_i)
      2'd1:    nr_live = KIDX_W'(12);
      2'd2:    nr_live = KIDX_W'(14);
      default: nr_live = KIDX_W'(10);
    endcase
  end
`else
  assign nr_live = KIDX_W'(NR_DEFAULT);
`endif

  // InvShiftRows is pure wiring into the per-byte inverse S-boxes
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int SRC = 4*((c - r + 4) % 4) + r;
      localparam int DST = 4*c + r;
      inv_sbox u_sbox (.a_i(st_q[127-8*SRC -: 8]), .y_o(sb[127-8*DST -: 8]));
    end
  end

  assign ark = sb ^ round_key_i;

  invmixcolumns u_imc (.d_i(ark), .q_o(mix));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      st_q    <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rnd_q   <= rnd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    rnd_d   = rnd_q;
    case (state_q)
      IDLE: if (in_valid_i) begin
        state_d = ROUND;
        st_d    = in_data_i ^ round_key_i;
        rnd_d   = nr_live - KIDX_W'(1);
      end
      ROUND: begin
        st_d  = mix;
        rnd_d = rnd_q - KIDX_W'(1);
        if (rnd_q == KIDX_W'(1)) state_d = FINAL;
      end
      FINAL: begin
        st_d    = ark;
        state_d = DONE;
      end
      DONE: if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    key_idx_o   = '0;
    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        key_idx_o  = nr_live;
      end
      ROUND, FINAL: begin
        busy_o    = 1'b1;
        key_idx_o = rnd_q;
      end
      DONE: out_valid_o = 1'b1;
      default: ;
    endcase
  end

  assign out_data_o = st_q;
endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: FIPS-197 vectors, random blocks against a byte-level AES model.
module tb_aes_inv_round_ctrl;
  localparam int KIDX_W = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [127:0]      in_data_i;
  logic [KIDX_W-1:0] key_idx_o;
  logic [127:0]      round_key_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [127:0]      out_data_o;
  logic              busy_o;
`ifdef AES_INV_KEYLEN_EN
  logic [1:0]        key_len_i;
`endif

  logic [15:0][127:0] cur_keys;
  assign round_key_i = cur_keys[key_idx_o];

  aes_inv_round_ctrl #(.NR_DEFAULT(10), .KIDX_W(KIDX_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .key_idx_o(key_idx_o), .round_key_i(round_key_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .busy_o(busy_o)
`ifdef AES_INV_KEYLEN_EN
    , .key_len_i(key_len_i)
`endif
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference arithmetic: polynomial product reduced mod x^8+x^4+x^3+x+1
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  logic [7:0] sbox_t [256];
  logic [7:0] isbox_t[256];

  task automatic build_tables();
    logic [7:0] y, s;
    for (int x = 0; x < 256; x++) begin
      y = 8'h00;
      for (int c = 1; c < 256; c++) if (gm(8'(x), 8'(c)) == 8'h01) y = 8'(c);
      s = y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
      sbox_t[x]  = s;
      isbox_t[s] = 8'(x);
    end
  endtask

  function automatic logic [15:0][127:0] expand(input logic [255:0] key, input int nk);
    logic [31:0] w[60];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [15:0][127:0] ks;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    ks = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
      end
      w[i] = t ^ w[i-nk];
    end
    for (int r = 0; r <= nr; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return ks;
  endfunction

  // Textbook InvCipher on a byte array, InvMixColumns as a circulant matrix product
  function automatic logic [127:0] ref_dec(input logic [127:0] ct, input logic [15:0][127:0] keys,
                                           input int nr);
    logic [7:0] s[16], t[16];
    logic [7:0] coef[4];
    logic [127:0] res;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ keys[nr][127-8*i -: 8];
    for (int r = nr - 1; r >= 0; r--) begin
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          t[4*c+w] = isbox_t[s[4*((c-w+4)%4)+w]] ^ keys[r][127-8*(4*c+w) -: 8];
      for (int c = 0; c < 4; c++)
        for (int i = 0; i < 4; i++) begin
          if (r > 0) begin
            s[4*c+i] = 8'h00;
            for (int j = 0; j < 4; j++) s[4*c+i] = s[4*c+i] ^ gm(coef[(j-i+4)%4], t[4*c+j]);
          end else begin
            s[4*c+i] = t[4*c+i];
          end
        end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  typedef struct {
    logic [127:0]       ct;
    logic [15:0][127:0] keys;
    logic [127:0]       exp;
    int                 nr;
    int                 stall;
    logic [1:0]         klen;
  } vec_t;

  vec_t vecs[8];
  int   nvec;

  task automatic run_block(input vec_t v);
    int cyc, bsy;
    bit trace_ok, hold_ok;
    logic [127:0] held;
    cur_keys = v.keys;
`ifdef AES_INV_KEYLEN_EN
    key_len_i = v.klen;
`endif
    in_data_i  = v.ct;
    in_valid_i = 1'b1;
    #1;
    chk("idle_key_idx", 128'(key_idx_o), 128'(v.nr));
    chk("idle_in_ready", 128'(in_ready_o), 128'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    in_data_i  = {$urandom, $urandom, $urandom, $urandom};
    cyc = 1; bsy = 0; trace_ok = 1'b1;
    while (!out_valid_o && cyc <= 40) begin
      if (key_idx_o != KIDX_W'(v.nr - cyc) || in_ready_o) trace_ok = 1'b0;
      bsy += int'(busy_o);
      @(negedge clk_i);
      cyc++;
    end
    chk("key_idx_trace", 128'(trace_ok), 128'd1);
    chk("latency", 128'(cyc - 1), 128'(v.nr));
    chk("busy_cycles", 128'(bsy), 128'(v.nr));
    chk("plaintext", out_data_o, v.exp);
    held = out_data_o; hold_ok = 1'b1; out_ready_i = 1'b0;
    for (int k = 0; k < v.stall; k++) begin
      @(negedge clk_i);
      if (!out_valid_o || out_data_o !== held || in_ready_o || busy_o) hold_ok = 1'b0;
    end
    if (v.stall > 0) chk("done_hold", 128'(hold_ok), 128'd1);
    out_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    out_ready_i = 1'b0;
    chk("post_hs_out_valid", 128'(out_valid_o), 128'd0);
    chk("post_hs_in_ready", 128'(in_ready_o), 128'd1);
  endtask

  initial begin
    logic [15:0][127:0] k128;
    int acc[2], hs[2], acc_n, hs_n;
    logic [127:0] got[2];
    rst_ni = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0; in_data_i = '0; cur_keys = '0;
`ifdef AES_INV_KEYLEN_EN
    key_len_i = 2'd0;
`endif
    build_tables();
    k128 = expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);

    vecs[0] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a, k128,
                128'h00112233445566778899aabbccddeeff, 10, 20, 2'd0};
    for (int i = 1; i < 5; i++) begin
      vecs[i].ct    = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].keys  = k128;
      if (i >= 3) for (int r = 0; r < 16; r++) vecs[i].keys[r] = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].nr    = 10;
      vecs[i].stall = (i == 1) ? 0 : int'($urandom_range(1, 5));
      vecs[i].klen  = 2'd0;
      vecs[i].exp   = ref_dec(vecs[i].ct, vecs[i].keys, 10);
    end
    nvec = 5;
`ifdef AES_INV_KEYLEN_EN
    vecs[5] = '{128'h8ea2b7ca516745bfeafc49904b496089,
                expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8),
                128'h00112233445566778899aabbccddeeff, 14, 2, 2'd2};
    for (int i = 6; i < 8; i++) begin
      vecs[i].ct = {$urandom, $urandom, $urandom, $urandom};
      for (int r = 0; r < 16; r++) vecs[i].keys[r] = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].klen  = (i == 6) ? 2'd1 : 2'd3;
      vecs[i].nr    = (i == 6) ? 12 : 10;
      vecs[i].stall = 1;
      vecs[i].exp   = ref_dec(vecs[i].ct, vecs[i].keys, vecs[i].nr);
    end
    nvec = 8;
`endif

    // Reset with in_valid already asserted: nothing may be accepted until rst_ni rises
    in_valid_i = 1'b1; in_data_i = vecs[0].ct; cur_keys = vecs[0].keys;
    repeat (3) @(negedge clk_i);
    chk("rst_in_ready", 128'(in_ready_o), 128'd1);
    chk("rst_out_valid", 128'(out_valid_o), 128'd0);
    chk("rst_busy", 128'(busy_o), 128'd0);
    chk("rst_key_idx", 128'(key_idx_o), 128'd10);
    chk("rst_state_reg", out_data_o, 128'h0);
    rst_ni = 1'b1;

    for (int i = 0; i < nvec; i++) run_block(vecs[i]);

    // Back-to-back with in_valid and out_ready held high
    cur_keys = k128;
`ifdef AES_INV_KEYLEN_EN
    key_len_i = 2'd0;
`endif
    in_data_i = vecs[0].ct; in_valid_i = 1'b1; out_ready_i = 1'b1;
    acc_n = 0; hs_n = 0; acc = '{0, 0}; hs = '{0, 0}; got = '{128'h0, 128'h0};
    for (int k = 0; k < 80; k++) begin
      if (in_valid_i && in_ready_o && acc_n < 2) begin acc[acc_n] = k; acc_n++; end
      if (out_valid_o && out_ready_i && hs_n < 2) begin got[hs_n] = out_data_o; hs[hs_n] = k; hs_n++; end
      if (hs_n == 2) break;
      @(posedge clk_i);
      @(negedge clk_i);
      if (acc_n == 1) in_data_i = vecs[1].ct;
      else if (acc_n == 2) in_valid_i = 1'b0;
    end
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    chk("b2b_handshakes", 128'(hs_n), 128'd2);
    chk("b2b_accepts", 128'(acc_n), 128'd2);
    chk("b2b_second_accept", 128'(acc[1]), 128'(hs[0] + 1));
    chk("b2b_out0", got[0], vecs[0].exp);
    chk("b2b_out1", got[1], vecs[1].exp);
    @(negedge clk_i);

    // Reset in the middle of the rounds
    in_data_i = vecs[0].ct; in_valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    repeat (4) @(negedge clk_i);
    rst_ni = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("midrst_in_ready", 128'(in_ready_o), 128'd1);
    chk("midrst_out_valid", 128'(out_valid_o), 128'd0);
    chk("midrst_key_idx", 128'(key_idx_o), 128'd10);
    chk("midrst_busy", 128'(busy_o), 128'd0);
    rst_ni = 1'b1;
    run_block(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
